// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: decode-side fields and the registered execute-side outputs.
// The master drives the decode side; the slave (the stage) drives the execute side.
interface id_ex_stage_if #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned OPCODE_LENGTH = 4,
    parameter int unsigned REG_ADDR_W    = 5
);
    logic                     stall;
    logic                     flush;
    logic                     in_valid;
    logic [DATA_WIDTH-1:0]    rd_data1;
    logic [DATA_WIDTH-1:0]    rd_data2;
    logic [DATA_WIDTH-1:0]    imm;
    logic                     alu_src;
    logic [1:0]               alu_op;
    logic [2:0]               funct3;
    logic                     funct7_b5;
    logic [REG_ADDR_W-1:0]    rd_addr;
    logic                     reg_write;
    logic                     mem_read;
    logic                     mem_write;
    logic                     mem_to_reg;

    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic [OPCODE_LENGTH-1:0] ALUCC;
    logic                     ex_valid;
    logic                     ex_reg_write;
    logic                     ex_mem_read;
    logic                     ex_mem_write;
    logic                     ex_mem_to_reg;
    logic                     ex_illegal;
    logic [REG_ADDR_W-1:0]    ex_rd_addr;
    logic [DATA_WIDTH-1:0]    ex_store_data;

    modport master (
        output stall, flush, in_valid, rd_data1, rd_data2, imm, alu_src, alu_op,
               funct3, funct7_b5, rd_addr, reg_write, mem_read, mem_write, mem_to_reg,
        input  SrcA, SrcB, ALUCC, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_illegal, ex_rd_addr, ex_store_data
    );

    modport slave (
        input  stall, flush, in_valid, rd_data1, rd_data2, imm, alu_src, alu_op,
               funct3, funct7_b5, rd_addr, reg_write, mem_read, mem_write, mem_to_reg,
        output SrcA, SrcB, ALUCC, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_illegal, ex_rd_addr, ex_store_data
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode; every output comes straight from a flop.
// Priority on each edge: reset > flush > stall > load (in_valid=0 loads a bubble).
module id_ex_stage #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned OPCODE_LENGTH = 4,
    parameter int unsigned REG_ADDR_W    = 5
) (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);
    localparam logic [OPCODE_LENGTH-1:0] CC_AND = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] CC_OR  = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] CC_ADD = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] CC_SUB = OPCODE_LENGTH'(4'b0110);

    logic [DATA_WIDTH-1:0]    r_src_a;
    logic [DATA_WIDTH-1:0]    r_src_b;
    logic [DATA_WIDTH-1:0]    r_store_data;
    logic [OPCODE_LENGTH-1:0] r_alucc;
    logic [REG_ADDR_W-1:0]    r_rd_addr;
    logic                     r_valid;
    logic                     r_reg_write;
    logic                     r_mem_read;
    logic                     r_mem_write;
    logic                     r_mem_to_reg;
    logic                     r_illegal;

    logic [OPCODE_LENGTH-1:0] w_alucc;
    logic                     w_legal;
    logic [DATA_WIDTH-1:0]    w_src_b;
    logic                     w_load_bubble;

    always_comb begin
        w_alucc = CC_ADD;
        w_legal = 1'b1;
        case (bus.alu_op)
            2'b00: w_alucc = CC_ADD;
            2'b01: w_alucc = CC_SUB;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  w_alucc = bus.funct7_b5 ? CC_SUB : CC_ADD;
                    3'b111:  w_alucc = CC_AND;
                    3'b110:  w_alucc = CC_OR;
                    default: w_legal = 1'b0;
                endcase
            end
            2'b11: begin
                // I-type: funct7 bit 30 belongs to the immediate, so it never selects SUB
                case (bus.funct3)
                    3'b000:  w_alucc = CC_ADD;
                    3'b111:  w_alucc = CC_AND;
                    3'b110:  w_alucc = CC_OR;
                    default: w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_src_b       = bus.alu_src ? bus.imm : bus.rd_data2;
    assign w_load_bubble = reset | bus.flush | (~bus.stall & ~bus.in_valid);

    always_ff @(posedge clk) begin
        if (w_load_bubble) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_illegal    <= 1'b0;
            r_rd_addr    <= '0;
            r_src_a      <= '0;
            r_src_b      <= '0;
            r_store_data <= '0;
            r_alucc      <= CC_ADD;
        end else if (!bus.stall) begin
            // Illegal encodings still advance as valid, but with side effects suppressed
            r_valid      <= 1'b1;
            r_reg_write  <= bus.reg_write & w_legal;
            r_mem_read   <= bus.mem_read & w_legal;
            r_mem_write  <= bus.mem_write & w_legal;
            r_mem_to_reg <= bus.mem_to_reg;
            r_illegal    <= ~w_legal;
            r_rd_addr    <= bus.rd_addr;
            r_src_a      <= bus.rd_data1;
            r_src_b      <= w_src_b;
            r_store_data <= bus.rd_data2;
            r_alucc      <= w_legal ? w_alucc : CC_ADD;
        end
    end

    assign bus.SrcA          = r_src_a;
    assign bus.SrcB          = r_src_b;
    assign bus.ALUCC         = r_alucc;
    assign bus.ex_valid      = r_valid;
    assign bus.ex_reg_write  = r_reg_write;
    assign bus.ex_mem_read   = r_mem_read;
    assign bus.ex_mem_write  = r_mem_write;
    assign bus.ex_mem_to_reg = r_mem_to_reg;
    assign bus.ex_illegal    = r_illegal;
    assign bus.ex_rd_addr    = r_rd_addr;
    assign bus.ex_store_data = r_store_data;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver predicts each edge's stage contents from
// the decode table and pipeline rules; a monitor compares them one cycle later.
module tb_id_ex_stage;
    localparam int unsigned DW  = 64;
    localparam int unsigned OL  = 4;
    localparam int unsigned RAW = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_ex_stage_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL), .REG_ADDR_W(RAW)) bus ();

    id_ex_stage #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL), .REG_ADDR_W(RAW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic           rst, stall, flush, in_valid, alu_src, f7;
        logic [1:0]     alu_op;
        logic [2:0]     f3;
        logic [DW-1:0]  rd1, rd2, imm;
        logic [RAW-1:0] rd;
        logic           rw, mr, mw, m2r;
    } stim_t;

    typedef struct {
        logic           valid, rw, mr, mw, m2r, ill;
        logic [RAW-1:0] rd;
        logic [DW-1:0]  a, b, sd;
        logic [OL-1:0]  cc;
    } exp_t;

    exp_t q[$];
    exp_t st;
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    function automatic exp_t bubble();
        exp_t e;
        e.valid = 0; e.rw = 0; e.mr = 0; e.mw = 0; e.m2r = 0; e.ill = 0;
        e.rd = '0; e.a = '0; e.b = '0; e.sd = '0; e.cc = 4'b0010;
        return e;
    endfunction

    // Reference decode table: returns 1 and the ALU code for legal encodings, 0 otherwise
    function automatic bit ref_decode(input logic [1:0] op, input logic [2:0] f3,
                                      input logic f7, output logic [OL-1:0] cc);
        cc = 4'b0010;
        if (op == 2'd0) begin cc = 4'b0010; return 1; end
        if (op == 2'd1) begin cc = 4'b0110; return 1; end
        if (f3 == 3'd7) begin cc = 4'b0000; return 1; end
        if (f3 == 3'd6) begin cc = 4'b0001; return 1; end
        if (f3 == 3'd0) begin
            cc = (op == 2'd2 && f7) ? 4'b0110 : 4'b0010;
            return 1;
        end
        return 0;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.rst = 0; s.stall = 0; s.flush = 0; s.in_valid = 0; s.alu_src = 0; s.f7 = 0;
        s.alu_op = 0; s.f3 = 0; s.rd1 = 0; s.rd2 = 0; s.imm = 0; s.rd = 0;
        s.rw = 0; s.mr = 0; s.mw = 0; s.m2r = 0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        int unsigned sel;
        s.rst      = ($urandom_range(99, 0) < 3);
        s.stall    = ($urandom_range(99, 0) < 25);
        s.flush    = ($urandom_range(99, 0) < 10);
        s.in_valid = ($urandom_range(99, 0) < 80);
        s.alu_src  = 1'($urandom);
        s.f7       = 1'($urandom);
        s.alu_op   = 2'($urandom);
        sel        = $urandom_range(3, 0);
        s.f3       = (sel == 0) ? 3'd0 : (sel == 1) ? 3'd6 : (sel == 2) ? 3'd7 : 3'($urandom);
        s.rd1      = {$urandom(), $urandom()};
        s.rd2      = {$urandom(), $urandom()};
        s.imm      = {$urandom(), $urandom()};
        s.rd       = RAW'($urandom);
        s.rw = 1'($urandom); s.mr = 1'($urandom); s.mw = 1'($urandom); s.m2r = 1'($urandom);
        return s;
    endfunction

    task automatic step(input stim_t s);
        logic [OL-1:0] cc;
        bit            legal;
        reset         = s.rst;
        bus.stall     = s.stall;
        bus.flush     = s.flush;
        bus.in_valid  = s.in_valid;
        bus.rd_data1  = s.rd1;
        bus.rd_data2  = s.rd2;
        bus.imm       = s.imm;
        bus.alu_src   = s.alu_src;
        bus.alu_op    = s.alu_op;
        bus.funct3    = s.f3;
        bus.funct7_b5 = s.f7;
        bus.rd_addr   = s.rd;
        bus.reg_write = s.rw;
        bus.mem_read  = s.mr;
        bus.mem_write = s.mw;
        bus.mem_to_reg = s.m2r;
        if (s.rst || s.flush) st = bubble();
        else if (s.stall) st = st;
        else if (!s.in_valid) st = bubble();
        else begin
            legal    = ref_decode(s.alu_op, s.f3, s.f7, cc);
            st.valid = 1;
            st.ill   = !legal;
            st.cc    = legal ? cc : 4'b0010;
            st.rw    = s.rw && legal;
            st.mr    = s.mr && legal;
            st.mw    = s.mw && legal;
            st.m2r   = s.m2r;
            st.rd    = s.rd;
            st.a     = s.rd1;
            st.b     = s.alu_src ? s.imm : s.rd2;
            st.sd    = s.rd2;
        end
        q.push_back(st);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("ex_valid",      DW'(bus.ex_valid),      DW'(e.valid));
                chk("ex_reg_write",  DW'(bus.ex_reg_write),  DW'(e.rw));
                chk("ex_mem_read",   DW'(bus.ex_mem_read),   DW'(e.mr));
                chk("ex_mem_write",  DW'(bus.ex_mem_write),  DW'(e.mw));
                chk("ex_mem_to_reg", DW'(bus.ex_mem_to_reg), DW'(e.m2r));
                chk("ex_illegal",    DW'(bus.ex_illegal),    DW'(e.ill));
                chk("ex_rd_addr",    DW'(bus.ex_rd_addr),    DW'(e.rd));
                chk("ALUCC",         DW'(bus.ALUCC),         DW'(e.cc));
                chk("SrcA",          bus.SrcA,               e.a);
                chk("SrcB",          bus.SrcB,               e.b);
                chk("ex_store_data", bus.ex_store_data,      e.sd);
            end else if (!done) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty got 0 entries expected 1 at %0t", $time);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "bench did not complete");
    end

    initial begin : driver
        stim_t s;
        st = bubble();

        s = idle(); s.rst = 1; s.in_valid = 1; s.stall = 1; s.flush = 1;
        step(s);
        s = idle(); s.rst = 1;
        step(s);

        // R-type SUB
        s = idle(); s.in_valid = 1; s.alu_op = 2'b10; s.f3 = 3'b000; s.f7 = 1;
        s.rd1 = 10; s.rd2 = 3; s.rd = 5; s.rw = 1;
        step(s);

        // I-type OR ignoring funct7_b5
        s = idle(); s.in_valid = 1; s.alu_op = 2'b11; s.f3 = 3'b110; s.f7 = 1;
        s.rd1 = 64'hF0; s.imm = 64'h0F; s.rd2 = 64'h1234; s.alu_src = 1; s.rw = 1;
        step(s);

        // Illegal R-type funct3
        s = idle(); s.in_valid = 1; s.alu_op = 2'b10; s.f3 = 3'b001; s.rw = 1; s.mw = 1;
        s.rd1 = 7; s.rd2 = 9; s.rd = 12;
        step(s);

        // Sign bit preserved on full-width operands
        s = idle(); s.in_valid = 1; s.alu_op = 2'b11; s.f3 = 3'b000; s.alu_src = 1;
        s.rd1 = 64'h8000_0000_0000_0001; s.imm = 64'hFFFF_FFFF_FFFF_FFF0; s.rd = 31; s.rw = 1;
        step(s);

        // Bubble on in_valid=0
        s = idle(); s.rd1 = 64'hDEAD; s.rw = 1;
        step(s);

        // ADD held across three stalls, then a new capture
        s = idle(); s.in_valid = 1; s.alu_op = 2'b00; s.rd1 = 100; s.rd2 = 200; s.imm = 8;
        s.alu_src = 1; s.rd = 3; s.mr = 1; s.rw = 1; s.m2r = 1;
        step(s);
        for (int i = 0; i < 3; i++) begin
            s = rand_stim(); s.rst = 0; s.flush = 0; s.stall = 1;
            step(s);
        end
        s = idle(); s.in_valid = 1; s.alu_op = 2'b01; s.rd1 = 55; s.rd2 = 66; s.rd = 9;
        step(s);

        // Flush wins over stall
        s = idle(); s.in_valid = 1; s.alu_op = 2'b10; s.f3 = 3'b111; s.rd1 = 1; s.rd2 = 2; s.rw = 1;
        step(s);
        s.stall = 1; s.flush = 1;
        step(s);

        // Reset mid-stall discards a held store; next edge loads normally
        s = idle(); s.in_valid = 1; s.alu_op = 2'b00; s.mw = 1; s.rd1 = 40; s.rd2 = 77; s.imm = 4;
        s.alu_src = 1;
        step(s);
        s.stall = 1;
        step(s);
        s.rst = 1;
        step(s);
        s = idle(); s.in_valid = 1; s.alu_op = 2'b00; s.mw = 1; s.rd1 = 80; s.rd2 = 5; s.imm = 16;
        s.alu_src = 1;
        step(s);

        for (int i = 0; i < 400; i++) begin
            s = rand_stim();
            step(s);
        end

        done = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
